nios2_jtag_debug_sysclk_cmdq: RTL and testbench
===============================================

// Module: nios2_jtag_debug_sysclk_cmdq
// PURPOSE
//  System-clock side of the Nios II JTAG debug bridge, generalised in widths and with a command queue.
//  Synchronises virtual-JTAG UIR/UDR strobes into clk and captures the IR and shift-register payload.
//  Queues each update-DR command and issues one-hot take_action / take_no_action pulses to the debug
//  logic (ocimem, break, trace); back-pressure via cmd_ready replaces the fixed single-shot decode.
// PARAMETERS
//  SR_WIDTH     38  width of TCK-domain shift register / jdo payload
//  IR_WIDTH     2   width of virtual-JTAG instruction register
//  SYNC_STAGES  2   synchroniser flops on vs_uir / vs_udr (>=2)
//  FIFO_DEPTH   4   command queue entries (power of two, >=2); AW = log2(FIFO_DEPTH)
// PORTS
//  clk             in   1              system clock
//  reset           in   1              asynchronous, active-high reset
//  vs_uir          in   1              update-IR level from TCK domain (asynchronous)
//  vs_udr          in   1              update-DR level from TCK domain (asynchronous)
//  ir_in           in   IR_WIDTH       TCK-domain IR; stable while vs_uir high
//  sr              in   SR_WIDTH       TCK-domain shift register; stable while vs_udr high
//  cmd_ready       in   1              debug logic accepts head command
//  ovf_clr         in   1              clears sticky overflow
//  cmd_valid       out  1              queue non-empty
//  cmd_ir          out  IR_WIDTH       IR of head command
//  cmd_data        out  SR_WIDTH       payload of head command
//  jdo             out  SR_WIDTH       payload of last popped command, held until next pop
//  take_action     out  2**IR_WIDTH    one-hot pulse: popped ir==k and payload MSB==1
//  take_no_action  out  2**IR_WIDTH    one-hot pulse: popped ir==k and payload MSB==0
//  fifo_level      out  AW+1           entries held (0..FIFO_DEPTH)
//  overflow        out  1              sticky: a command was dropped on a full queue
// BEHAVIOUR
//  - Reset: sync and edge-history flops -> all 1s; ir_reg, jdo, pointers -> 0; cmd_valid, fifo_level,
//    overflow, take_action, take_no_action -> 0. cmd_ir/cmd_data undefined while cmd_valid=0.
//  - Strobes high through reset release produce no edge; a low must propagate first.
//  - Sync: each strobe through SYNC_STAGES flops; rise = sync_out & ~sync_prev (single-cycle).
//  - uir_rise: ir_reg <= ir_in. udr_rise: push {ir_sel, sr}; ir_sel = ir_in if uir_rise same cycle,
//    else ir_reg. sr and ir_in are sampled in the rise cycle only.
//  - Latency: vs_udr first sampled high at edge N -> push at edge N+SYNC_STAGES -> cmd_valid=1
//    after that edge (SYNC_STAGES+1 edges after first high sample).
//  - Handshake: pop = cmd_valid & cmd_ready. cmd_ready is ignored when cmd_valid=0.
//    At the pop edge: jdo <= cmd_data; take_action/take_no_action[cmd_ir] pulse high for exactly the
//    next cycle, else 0. At most one of the two vectors is non-zero, with one bit set.
//  - Push while full without pop: command dropped, overflow <= 1, queue unchanged.
//    Push and pop together while full: both performed, no overflow.
//    Push and pop together at any level: level unchanged. Push while empty: head visible next cycle
//    (no bypass).
//  - overflow: a set event takes priority over ovf_clr in the same cycle.
//  - Pointers are AW+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and low bits equal.
//  - fifo_level = wr_ptr - rd_ptr (AW+1 bits); cmd_valid = (fifo_level != 0).
//  - Reset mid-operation: queue flushed, in-flight pulses cleared, overflow cleared.
//  - Storage: flop array of (IR_WIDTH+SR_WIDTH) bits; head read is combinational from rd_ptr.
// TESTING
//  1 Reset with vs_udr=1 held, release, hold 10 clk -> cmd_valid=0, fifo_level=0, no pulses.
//  2 vs_uir pulse with ir_in=2'b01, then vs_udr pulse with sr=38'h20_0000_1234, cmd_ready=1
//    -> cmd_valid 3 edges after first vs_udr high sample; next cycle take_action=4'b0010 for 1 clk,
//    jdo=38'h20_0000_1234.
//  3 ir=2'b00, sr MSB=0 (38'h00_0000_00AB), cmd_ready=1 -> take_no_action=4'b0001 one cycle;
//    take_action=0.
//  4 cmd_ready=0, 5 distinct udr commands -> fifo_level=4, overflow=1, 5th dropped; drain in order
//    1..4; ovf_clr -> overflow=0.
//  5 Queue full; 5th udr rise in the same cycle as a pop -> no overflow, level stays 4, order kept.
//  6 Assert reset with 3 queued entries and a pulse pending -> all outputs 0 next cycle;
//    after release the queue is empty.

Source files
------------

// File: rtl/nios2_jtag_debug_sysclk_cmdq_if.sv
// Command handshake between the JTAG bridge queue head and the debug logic.
interface nios2_jtag_debug_sysclk_cmdq_if #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned SR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;

  // Queue side: presents the head command, receives acceptance.
  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_data,
    input  cmd_ready
  );

  // Debug-logic side: consumes the head command.
  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/nios2_jtag_debug_sysclk_cmdq.sv
// System-clock side of the Nios II JTAG debug bridge: synchronises the
// virtual-JTAG update strobes, queues update-DR commands and issues one-hot
// take_action / take_no_action pulses as each command is accepted.
module nios2_jtag_debug_sysclk_cmdq #(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vs_uir,
  input  logic                            vs_udr,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic [SR_WIDTH-1:0]             sr,
  input  logic                            ovf_clr,
  nios2_jtag_debug_sysclk_cmdq_if.master  cmd,
  output logic [SR_WIDTH-1:0]             jdo,
  output logic [(2**IR_WIDTH)-1:0]        take_action,
  output logic [(2**IR_WIDTH)-1:0]        take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NA = 2 ** IR_WIDTH;
  localparam int unsigned EW = IR_WIDTH + SR_WIDTH;

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_prev;
  logic                   udr_prev;
  logic                   uir_rise;
  logic                   udr_rise;

  logic [IR_WIDTH-1:0]    ir_reg;
  logic [IR_WIDTH-1:0]    ir_sel;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   full;
  logic                   pop;
  logic                   push_ok;
  logic                   ovf_set;
  logic [EW-1:0]          head;
  logic [IR_WIDTH-1:0]    head_ir;
  logic [SR_WIDTH-1:0]    head_data;
  logic [NA-1:0]          head_onehot;

  // Strobe synchronisers; preset high so strobes held through reset make no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync <= '1;
      udr_sync <= '1;
      uir_prev <= 1'b1;
      udr_prev <= 1'b1;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_prev <= uir_sync[SYNC_STAGES-1];
      udr_prev <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_prev;
  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_prev;

  // A same-cycle IR update applies to the command being pushed.
  assign ir_sel = uir_rise ? ir_in : ir_reg;

  // Captured instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg <= '0;
    end else if (uir_rise) begin
      ir_reg <= ir_in;
    end
  end

  assign fifo_level    = wr_ptr - rd_ptr;
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd.cmd_valid = (fifo_level != '0);
  assign pop           = cmd.cmd_valid & cmd.cmd_ready;
  assign push_ok       = udr_rise & (~full | pop);
  assign ovf_set       = udr_rise & full & ~pop;

  assign head          = mem[rd_ptr[AW-1:0]];
  assign head_ir       = head[EW-1:SR_WIDTH];
  assign head_data     = head[SR_WIDTH-1:0];
  assign cmd.cmd_ir    = head_ir;
  assign cmd.cmd_data  = head_data;

  // Decode head IR into its one-hot action slot.
  always_comb begin
    head_onehot          = '0;
    head_onehot[head_ir] = 1'b1;
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {ir_sel, sr};
    end
  end

  // Queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Pop side: latch payload into jdo and fire a single-cycle action pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo <= head_data;
        if (head_data[SR_WIDTH-1]) take_action    <= head_onehot;
        else                       take_no_action <= head_onehot;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_jtag_debug_sysclk_cmdq.sv
// Directed bench for the JTAG debug command queue.
module tb_nios2_jtag_debug_sysclk_cmdq;

  localparam int unsigned SR_WIDTH = 38;
  localparam int unsigned IR_WIDTH = 2;
  localparam int unsigned DEPTH    = 4;

  logic                 clk;
  logic                 reset;
  logic                 vs_uir;
  logic                 vs_udr;
  logic [IR_WIDTH-1:0]  ir_in;
  logic [SR_WIDTH-1:0]  sr;
  logic                 ovf_clr;
  logic [SR_WIDTH-1:0]  jdo;
  logic [3:0]           take_action;
  logic [3:0]           take_no_action;
  logic [2:0]           fifo_level;
  logic                 overflow;

  int n_cmp;
  int n_mis;

  logic [SR_WIDTH-1:0] vals [5];

  nios2_jtag_debug_sysclk_cmdq_if #(.IR_WIDTH(IR_WIDTH), .SR_WIDTH(SR_WIDTH)) cmd_if ();

  nios2_jtag_debug_sysclk_cmdq #(
    .SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .ovf_clr(ovf_clr), .cmd(cmd_if.master), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .fifo_level(fifo_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_uir(input logic [IR_WIDTH-1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (3) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  // Pushes one command (cmd_ready assumed low) and lets the strobe return low.
  task automatic queue_cmd(input logic [SR_WIDTH-1:0] v);
    sr     = v;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 3'd0 ||
          take_action !== 4'd0 || take_no_action !== 4'd0) begin
        n_mis++;
        $display("FAIL reset_hold cyc%0d: valid=%b level=%0d ta=%b tna=%b want 0/0/0/0",
                 i, cmd_if.cmd_valid, fifo_level, take_action, take_no_action);
      end
    end
    n_cmp++;
    if (jdo !== '0 || overflow !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_regs: jdo=%h ovf=%b want 0/0", jdo, overflow);
    end
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_action();
    cmd_if.cmd_ready = 1'b1;
    pulse_uir(2'b01);
    sr     = 38'h20_0000_1234;
    vs_udr = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if (cmd_if.cmd_valid !== (e == 3)) begin
        n_mis++;
        $display("FAIL action_latency edge%0d: valid=%b want %b", e, cmd_if.cmd_valid, e == 3);
      end
    end
    tick();
    n_cmp++;
    if (take_action !== 4'b0010 || take_no_action !== 4'b0000 || jdo !== 38'h20_0000_1234) begin
      n_mis++;
      $display("FAIL action_pulse: ta=%b tna=%b jdo=%h want 0010/0000/2000001234",
               take_action, take_no_action, jdo);
    end
    vs_udr = 1'b0;
    tick();
    n_cmp++;
    if (take_action !== 4'b0000 || cmd_if.cmd_valid !== 1'b0 || jdo !== 38'h20_0000_1234) begin
      n_mis++;
      $display("FAIL action_one_cycle: ta=%b valid=%b jdo=%h want 0000/0/2000001234",
               take_action, cmd_if.cmd_valid, jdo);
    end
    repeat (2) tick();
  endtask

  task automatic test_no_action();
    cmd_if.cmd_ready = 1'b1;
    pulse_uir(2'b00);
    sr     = 38'h00_0000_00AB;
    vs_udr = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (take_no_action !== 4'b0001 || take_action !== 4'b0000 || jdo !== 38'h00_0000_00AB) begin
      n_mis++;
      $display("FAIL no_action_pulse: tna=%b ta=%b jdo=%h want 0001/0000/00000000ab",
               take_no_action, take_action, jdo);
    end
    vs_udr = 1'b0;
    tick();
    n_cmp++;
    if (take_no_action !== 4'b0000 || take_action !== 4'b0000) begin
      n_mis++;
      $display("FAIL no_action_one_cycle: tna=%b ta=%b want 0000/0000", take_no_action, take_action);
    end
    repeat (2) tick();
  endtask

  task automatic drain_one(input logic [SR_WIDTH-1:0] exp, input string tag);
    logic [3:0] exp_ta;
    logic [3:0] exp_tna;
    exp_ta  = exp[SR_WIDTH-1] ? 4'b0100 : 4'b0000;
    exp_tna = exp[SR_WIDTH-1] ? 4'b0000 : 4'b0100;
    n_cmp++;
    if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_data !== exp || cmd_if.cmd_ir !== 2'b10) begin
      n_mis++;
      $display("FAIL %s_head: valid=%b ir=%b data=%h want 1/10/%h",
               tag, cmd_if.cmd_valid, cmd_if.cmd_ir, cmd_if.cmd_data, exp);
    end
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    n_cmp++;
    if (jdo !== exp || take_action !== exp_ta || take_no_action !== exp_tna) begin
      n_mis++;
      $display("FAIL %s_pop: jdo=%h ta=%b tna=%b want %h/%b/%b",
               tag, jdo, take_action, take_no_action, exp, exp_ta, exp_tna);
    end
  endtask

  task automatic test_overflow();
    cmd_if.cmd_ready = 1'b0;
    pulse_uir(2'b10);
    vals[0] = 38'h20_0000_0001;
    vals[1] = 38'h00_0000_0002;
    vals[2] = 38'h3F_FFFF_FFF3;
    vals[3] = 38'h00_1234_5674;
    vals[4] = 38'h20_AAAA_5555;
    for (int i = 0; i < 4; i++) queue_cmd(vals[i]);
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_mis++;
      $display("FAIL ovf_fill: level=%0d ovf=%b want 4/0", fifo_level, overflow);
    end
    queue_cmd(vals[4]);
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      n_mis++;
      $display("FAIL ovf_drop: level=%0d ovf=%b want 4/1", fifo_level, overflow);
    end
    for (int i = 0; i < 4; i++) drain_one(vals[i], "ovf_drain");
    tick();
    n_cmp++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b1) begin
      n_mis++;
      $display("FAIL ovf_empty: valid=%b level=%0d ovf=%b want 0/0/1",
               cmd_if.cmd_valid, fifo_level, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_mis++;
      $display("FAIL ovf_clr: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    cmd_if.cmd_ready = 1'b0;
    vals[0] = 38'h00_0000_0011;
    vals[1] = 38'h20_0000_0022;
    vals[2] = 38'h00_0000_0033;
    vals[3] = 38'h20_0000_0044;
    vals[4] = 38'h00_0000_0055;
    for (int i = 0; i < 4; i++) queue_cmd(vals[i]);
    sr     = vals[4];
    vs_udr = 1'b1;
    repeat (2) tick();
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 || jdo !== vals[0]) begin
      n_mis++;
      $display("FAIL b2b_push_pop: level=%0d ovf=%b jdo=%h want 4/0/%h",
               fifo_level, overflow, jdo, vals[0]);
    end
    vs_udr = 1'b0;
    repeat (3) tick();
    for (int i = 1; i < 5; i++) drain_one(vals[i], "b2b_drain");
  endtask

  task automatic test_reset_mid();
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) queue_cmd(38'h20_0000_0100 + 38'(i));
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd3 || take_action !== 4'b0100) begin
      n_mis++;
      $display("FAIL rst_mid_pre: level=%0d ta=%b want 3/0100", fifo_level, take_action);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 3'd0 || take_action !== 4'd0 ||
        take_no_action !== 4'd0 || overflow !== 1'b0 || jdo !== '0) begin
      n_mis++;
      $display("FAIL rst_mid: valid=%b level=%0d ta=%b tna=%b ovf=%b jdo=%h want all 0",
               cmd_if.cmd_valid, fifo_level, take_action, take_no_action, overflow, jdo);
    end
    reset = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_mis++;
      $display("FAIL rst_mid_after: valid=%b level=%0d want 0/0", cmd_if.cmd_valid, fifo_level);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    vs_uir = 1'b0;
    vs_udr = 1'b1;
    ir_in = '0;
    sr = '0;
    ovf_clr = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_action();
    test_no_action();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
